delay_timer_arbiter: RTL and testbench
======================================

DELAY_TIMER_ARBITER -- requirements
Module: delay_timer_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters, range 2..8.
REQ-002 Parameter DIV, 1_000_000, clk cycles per tick, minimum 2.
REQ-003 Parameter CNT_W, 8, width of each requester's tick-count field.
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  level request per requester; held high until done or abort.
REQ-007 delay  in  NREQ*CNT_W  tick count per requester; requester i uses bits [i*CNT_W +: CNT_W].
REQ-008 grant  out  NREQ  one-hot owner of the shared timer; all-zero when idle.
REQ-009 done  out  NREQ  one-cycle completion pulse to the owner.
REQ-010 busy  out  1  high while in RUN or DONE.
REQ-011 tick  out  1  one-cycle pulse at each prescaler wrap while in RUN.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE, any req high: pick the first requester searching upward from (last_winner+1) mod NREQ, wrapping.
- On the next edge: grant[w]=1, remaining=delay[w], prescaler=0.
- Next state: RUN, or DONE directly if delay[w]==0.
REQ-014 IDLE, no req high: outputs SHALL stay at reset values.
REQ-015 RUN, prescaler < DIV-1: prescaler increments.
REQ-016 RUN, prescaler == DIV-1: prescaler returns to 0, tick=1 that cycle, remaining decrements.
- If remaining was 1 before the decrement, next state is DONE.
REQ-017 Latency: with grant rising at edge E0, the D-th tick SHALL occur in cycle E0+D*DIV-1 and done[w] SHALL be high in cycle E0+D*DIV (D>=1).
- For D==0, done[w] is high in cycle E0 and no tick occurs.
REQ-018 DONE lasts exactly one cycle: done[w]=1, grant[w] still 1.
- On the next edge: grant cleared, last_winner=w, state IDLE.
REQ-019 A requester whose req is still high after done SHALL be re-arbitrated normally.
- It receives lowest priority relative to the other requesters.
REQ-020 Requests asserted during RUN/DONE SHALL be ignored until IDLE; no request is lost while its req stays high.
REQ-021 delay SHALL be sampled only at grant time; later changes have no effect on the active run.
REQ-022 remaining SHALL never underflow; delay = 2^CNT_W-1 SHALL complete normally.
REQ-023 done and grant SHALL never be asserted for more than one requester at once.
REQ-024 A new grant SHALL be issued no earlier than one cycle after DONE (one IDLE cycle minimum).

Reset
REQ-025 On reset, the following SHALL hold on the next edge, overriding any state:
- State IDLE; grant, done, busy and tick all 0.
- Prescaler and remaining 0; last_winner=NREQ-1, so requester 0 has first priority.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abandon the run with no done pulse.

Configuration
REQ-027 Macro TIMER_ARB_ABORT_EN enables the abort feature.
REQ-028 With TIMER_ARB_ABORT_EN defined: req[w] low during RUN aborts the run.
- On the next edge: grant cleared, no done, state IDLE, last_winner=w.
- req[w] low during DONE does not suppress done.
REQ-029 Without TIMER_ARB_ABORT_EN: req deassertion during RUN SHALL be ignored and the run SHALL complete with done.

Verification (DIV=4, NREQ=4, CNT_W=8)
REQ-030 req[0]=1, delay0=3 from idle -> grant[0] rises next edge (E0).
- Ticks in cycles E0+3, E0+7, E0+11; done[0] in cycle E0+12; grant low at E0+13.
REQ-031 req[0] and req[2] held high from reset, delays 1 -> grant order 0, 2, 0, 2.
- Each done is 4 cycles after its grant; one IDLE cycle between runs.
REQ-032 req[3]=1, delay3=0 -> done[3] in the grant cycle, tick never asserted, busy high 1 cycle.
REQ-033 req[1]=1, delay1=5, req[1] dropped at E0+6:
- With TIMER_ARB_ABORT_EN: grant[1] low at E0+7, no done.
- Without the macro: done[1] at E0+20.
REQ-034 reset pulsed at E0+9 of a delay=4 run -> all outputs 0 next cycle.
- With req[0] and req[1] both high afterwards, requester 0 is granted first.
REQ-035 delay0=255 -> exactly 255 ticks, done[0] at E0+1020, no wrap or early done.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: round-robin owner of one shared prescaled tick-down timer.
// Define TIMER_ARB_ABORT_EN to let the owner abort a run by dropping its req.
module delay_timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int DIV   = 1_000_000,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] delay,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  tick
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DIV);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t            r_state, w_next;
  logic [PW-1:0]     r_presc;
  logic [CNT_W-1:0]  r_rem;
  logic [IW-1:0]     r_owner, r_last, w_win;
  logic [CNT_W-1:0]  w_dly;
  logic              w_found, w_wrap, w_abort;
  // Scan from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin : p_arb
    logic [IW-1:0] l_i;
    l_i = '0;
    w_found = 1'b0;
    w_win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      l_i = IW'((int'(r_last) + k) % NREQ);
      if (req[l_i]) begin
        w_found = 1'b1;
        w_win = l_i;
      end
    end
  end
  assign w_dly  = delay[int'(w_win)*CNT_W +: CNT_W];
  assign w_wrap = r_presc == PW'(DIV - 1);
`ifdef TIMER_ARB_ABORT_EN
  assign w_abort = ~req[r_owner];
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_rem   <= '0;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_owner <= w_win;
        r_rem   <= w_dly;
        r_presc <= '0;
      end
      if (r_state == S_RUN) begin
        r_presc <= w_wrap ? '0 : r_presc + 1'b1;
        if (w_wrap) r_rem <= r_rem - 1'b1;
      end
      if (r_state != S_IDLE && w_next == S_IDLE) r_last <= r_owner;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_found ? ((w_dly == '0) ? S_DONE : S_RUN) : S_IDLE;
      S_RUN:   w_next = w_abort ? S_IDLE : ((w_wrap && r_rem == CNT_W'(1)) ? S_DONE : S_RUN);
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    grant = (r_state != S_IDLE) ? (NREQ'(1) << r_owner) : '0;
    done  = (r_state == S_DONE) ? (NREQ'(1) << r_owner) : '0;
    busy  = r_state != S_IDLE;
    tick  = r_state == S_RUN && w_wrap;
  end
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// tb_delay_timer_arbiter: directed scenarios plus random traffic against a
// timeline model (grant age in cycles) of the arbiter.
module tb_delay_timer_arbiter;
  localparam int NREQ = 4;
  localparam int DIV = 4;
  localparam int CNT_W = 8;
`ifdef TIMER_ARB_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req;
  logic [NREQ*CNT_W-1:0] delay;
  logic [NREQ-1:0] grant, done;
  logic busy, tick;
  int checks = 0, errors = 0, cyc = 0;
  int m_active = 0, m_owner = 0, m_age = 0, m_d = 0, m_last = NREQ - 1;
  int g_cyc = 0, d_cyc = 0, tick_cnt = 0, busy_cnt = 0;
  logic [NREQ-1:0] prev_grant = '0;
  int order[$];
  delay_timer_arbiter #(.NREQ(NREQ), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .delay(delay),
    .grant(grant), .done(done), .busy(busy), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Model: a run is just "owner, delay D, age since grant"; done at age D*DIV.
  task automatic model_edge();
    bit found;
    int i;
    found = 1'b0;
    if (reset) begin
      m_active = 0;
      m_last = NREQ - 1;
    end else if (m_active == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (!found && req[i]) begin
          found = 1'b1;
          m_active = 1;
          m_owner = i;
          m_d = int'(delay[i*CNT_W +: CNT_W]);
          m_age = 0;
        end
      end
    end else if (m_age == m_d * DIV || (ABORT && !req[m_owner])) begin
      m_active = 0;
      m_last = m_owner;
    end else m_age++;
  endtask
  task automatic step();
    int exp_g, exp_d, exp_t;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    exp_g = m_active != 0 ? (1 << m_owner) : 0;
    exp_d = (m_active != 0 && m_age == m_d * DIV) ? (1 << m_owner) : 0;
    exp_t = (m_active != 0 && m_age < m_d * DIV && m_age % DIV == DIV - 1) ? 1 : 0;
    chk("grant", 32'(grant), exp_g);
    chk("done", 32'(done), exp_d);
    chk("busy", 32'(busy), m_active != 0 ? 1 : 0);
    chk("tick", 32'(tick), exp_t);
    chk("grant_onehot", 32'($onehot0(grant)), 1);
    if (grant != '0 && prev_grant == '0) begin
      g_cyc = cyc;
      for (int j = 0; j < NREQ; j++) if (grant[j]) order.push_back(j);
    end
    if (done != '0) d_cyc = cyc;
    if (tick) tick_cnt++;
    if (busy) busy_cnt++;
    prev_grant = grant;
  endtask
  task automatic run_until_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < max && !seen; n++) begin
      step();
      seen = done != '0;
    end
    chk("done_seen", 32'(seen), 1);
  endtask
  task automatic wait_grant(input int idx, input int max);
    for (int n = 0; n < max && !grant[idx]; n++) step();
    chk("grant_seen", 32'(grant[idx]), 1);
  endtask
  initial begin
    reset = 1'b1;
    req = '0;
    delay = '0;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    delay[0 +: CNT_W] = 8'd3;
    req = 4'b0001;
    tick_cnt = 0;
    run_until_done(30);
    req = '0;
    chk("r30_latency", d_cyc - g_cyc, 12);
    chk("r30_ticks", tick_cnt, 3);
    step();
    chk("r30_grant_low", 32'(grant), 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    order.delete();
    delay[0 +: CNT_W] = 8'd1;
    delay[2*CNT_W +: CNT_W] = 8'd1;
    req = 4'b0101;
    for (int n = 0; n < 24; n++) step();
    req = '0;
    chk("r31_count", order.size(), 4);
    chk("r31_order0", order.size() > 0 ? order[0] : -1, 0);
    chk("r31_order1", order.size() > 1 ? order[1] : -1, 2);
    chk("r31_order2", order.size() > 2 ? order[2] : -1, 0);
    chk("r31_order3", order.size() > 3 ? order[3] : -1, 2);
    step();
    step();
    delay[3*CNT_W +: CNT_W] = 8'd0;
    req = 4'b1000;
    tick_cnt = 0;
    busy_cnt = 0;
    run_until_done(10);
    req = '0;
    chk("r32_same_cycle", d_cyc - g_cyc, 0);
    step();
    step();
    chk("r32_busy_cycles", busy_cnt, 1);
    chk("r32_ticks", tick_cnt, 0);
    delay[CNT_W +: CNT_W] = 8'd5;
    req = 4'b0010;
    wait_grant(1, 10);
    for (int n = 0; n < 5; n++) step();
    req[1] = 1'b0;
    for (int n = 0; n < 20; n++) step();
    delay[0 +: CNT_W] = 8'd4;
    req = 4'b0001;
    wait_grant(0, 10);
    for (int n = 0; n < 8; n++) step();
    reset = 1'b1;
    req = 4'b0011;
    step();
    chk("r34_grant", 32'(grant), 0);
    chk("r34_busy", 32'(busy), 0);
    reset = 1'b0;
    order.delete();
    run_until_done(30);
    chk("r34_first", order.size() > 0 ? order[0] : -1, 0);
    req = '0;
    step();
    step();
    step();
    delay[0 +: CNT_W] = 8'd255;
    req = 4'b0001;
    tick_cnt = 0;
    run_until_done(1100);
    req = '0;
    chk("r35_latency", d_cyc - g_cyc, 1020);
    chk("r35_ticks", tick_cnt, 255);
    step();
    step();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0)
        delay[$urandom_range(0, NREQ - 1)*CNT_W +: CNT_W] = 8'($urandom_range(0, 3));
      reset = $urandom_range(0, 299) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
